// File: rtl/mwrite_if.sv
// Store bus between the mwrite stage (master) and the MMU (slave).
// Handshake: DATA_WREN high means the store is offered. WADDR/WDATA are stable while it is offered,
// and the store transfers on the first rising edge where DATA_WREN and DATA_WREADY are both high.
interface mwrite_if;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [31:0] DATA_WDATA;
    logic        DATA_WREADY;

    modport master (
        output DATA_WREN,
        output DATA_WADDR,
        output DATA_WDATA,
        input  DATA_WREADY
    );

    modport slave (
        input  DATA_WREN,
        input  DATA_WADDR,
        input  DATA_WDATA,
        output DATA_WREADY
    );
endinterface

// File: rtl/mwrite.sv
// Memory-write pipeline stage. It captures the read-stage results and performs the store to the MMU,
// with a bounded wait. It stalls upstream while a store is in flight.
module mwrite #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        MEM_WAIT,
    input  logic [4:0]  MEMR_REG_W_RD,
    input  logic [31:0] MEMR_REG_W_DATA,
    input  logic [11:0] MEMR_CSR_W_ADDR,
    input  logic [31:0] MEMR_CSR_W_DATA,
    input  logic        MEMR_MEM_W_VALID,
    input  logic [31:0] MEMR_MEM_W_ADDR,
    input  logic [3:0]  MEMR_MEM_W_STRB,
    input  logic [31:0] MEMR_MEM_W_DATA,
    input  logic        MEMR_JMP_DO,
    input  logic [31:0] MEMR_JMP_PC,
    mwrite_if.master    dbus,
    output logic        MEMW_BUSY,
    output logic        MEMW_WERR,
    output logic [4:0]  MEMW_REG_W_RD,
    output logic [31:0] MEMW_REG_W_DATA,
    output logic [11:0] MEMW_CSR_W_ADDR,
    output logic [31:0] MEMW_CSR_W_DATA,
    output logic        MEMW_JMP_DO,
    output logic [31:0] MEMW_JMP_PC
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        werr_q, werr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [31:0] csr_data_q, csr_data_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        jmp_do_q, jmp_do_d;
    logic [31:0] jmp_pc_q, jmp_pc_d;

    // Strobe is informational (data arrives pre-merged) and the address is word-aligned on output.
    logic unused_bits;
    assign unused_bits = ^{MEMR_MEM_W_STRB, waddr_q[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        werr_d     = 1'b0;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        csr_addr_d = csr_addr_q;
        csr_data_d = csr_data_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        jmp_do_d   = jmp_do_q;
        jmp_pc_d   = jmp_pc_q;

        case (state_q)
            IDLE: begin
                if (!MEM_WAIT) begin
                    if (FLUSH) begin
                        rd_d       = '0;
                        rdata_d    = '0;
                        csr_addr_d = '0;
                        csr_data_d = '0;
                        waddr_d    = '0;
                        wdata_d    = '0;
                        jmp_do_d   = 1'b0;
                        jmp_pc_d   = '0;
                    end else begin
                        rd_d       = MEMR_REG_W_RD;
                        rdata_d    = MEMR_REG_W_DATA;
                        csr_addr_d = MEMR_CSR_W_ADDR;
                        csr_data_d = MEMR_CSR_W_DATA;
                        waddr_d    = MEMR_MEM_W_ADDR;
                        wdata_d    = MEMR_MEM_W_DATA;
                        jmp_do_d   = MEMR_JMP_DO;
                        jmp_pc_d   = MEMR_JMP_PC;
                        if (MEMR_MEM_W_VALID) begin
                            state_d = WRITE;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            WRITE: begin
                // The store is committed, so neither MEM_WAIT nor FLUSH stops the handshake.
                if (dbus.DATA_WREADY) begin
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d = IDLE;
                    werr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (FLUSH && !MEM_WAIT) begin
                    rd_d       = '0;
                    rdata_d    = '0;
                    csr_addr_d = '0;
                    csr_data_d = '0;
                    jmp_do_d   = 1'b0;
                    jmp_pc_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            werr_q     <= 1'b0;
            rd_q       <= '0;
            rdata_q    <= '0;
            csr_addr_q <= '0;
            csr_data_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            jmp_do_q   <= 1'b0;
            jmp_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            werr_q     <= werr_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
            csr_addr_q <= csr_addr_d;
            csr_data_q <= csr_data_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            jmp_do_q   <= jmp_do_d;
            jmp_pc_q   <= jmp_pc_d;
        end
    end

    assign MEMW_BUSY       = (state_q == WRITE);
    assign MEMW_WERR       = werr_q;
    assign dbus.DATA_WREN  = (state_q == WRITE);
    assign dbus.DATA_WADDR = {waddr_q[31:2], 2'b00};
    assign dbus.DATA_WDATA = wdata_q;
    assign MEMW_REG_W_RD   = rd_q;
    assign MEMW_REG_W_DATA = rdata_q;
    assign MEMW_CSR_W_ADDR = csr_addr_q;
    assign MEMW_CSR_W_DATA = csr_data_q;
    assign MEMW_JMP_DO     = jmp_do_q;
    assign MEMW_JMP_PC     = jmp_pc_q;

endmodule

// File: tb/tb_mwrite.sv
// Self-checking bench for mwrite: stores are scoreboarded at the MMU handshake, other outputs checked inline.
module tb_mwrite;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        FLUSH = 1'b0;
    logic        MEM_WAIT = 1'b0;
    logic [4:0]  MEMR_REG_W_RD = '0;
    logic [31:0] MEMR_REG_W_DATA = '0;
    logic [11:0] MEMR_CSR_W_ADDR = '0;
    logic [31:0] MEMR_CSR_W_DATA = '0;
    logic        MEMR_MEM_W_VALID = 1'b0;
    logic [31:0] MEMR_MEM_W_ADDR = '0;
    logic [3:0]  MEMR_MEM_W_STRB = '0;
    logic [31:0] MEMR_MEM_W_DATA = '0;
    logic        MEMR_JMP_DO = 1'b0;
    logic [31:0] MEMR_JMP_PC = '0;
    logic        MEMW_BUSY, MEMW_WERR;
    logic [4:0]  MEMW_REG_W_RD;
    logic [31:0] MEMW_REG_W_DATA;
    logic [11:0] MEMW_CSR_W_ADDR;
    logic [31:0] MEMW_CSR_W_DATA;
    logic        MEMW_JMP_DO;
    logic [31:0] MEMW_JMP_PC;

    mwrite_if dbus ();

    mwrite #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .MEMR_REG_W_RD(MEMR_REG_W_RD), .MEMR_REG_W_DATA(MEMR_REG_W_DATA),
        .MEMR_CSR_W_ADDR(MEMR_CSR_W_ADDR), .MEMR_CSR_W_DATA(MEMR_CSR_W_DATA),
        .MEMR_MEM_W_VALID(MEMR_MEM_W_VALID), .MEMR_MEM_W_ADDR(MEMR_MEM_W_ADDR),
        .MEMR_MEM_W_STRB(MEMR_MEM_W_STRB), .MEMR_MEM_W_DATA(MEMR_MEM_W_DATA),
        .MEMR_JMP_DO(MEMR_JMP_DO), .MEMR_JMP_PC(MEMR_JMP_PC),
        .dbus(dbus.master),
        .MEMW_BUSY(MEMW_BUSY), .MEMW_WERR(MEMW_WERR),
        .MEMW_REG_W_RD(MEMW_REG_W_RD), .MEMW_REG_W_DATA(MEMW_REG_W_DATA),
        .MEMW_CSR_W_ADDR(MEMW_CSR_W_ADDR), .MEMW_CSR_W_DATA(MEMW_CSR_W_DATA),
        .MEMW_JMP_DO(MEMW_JMP_DO), .MEMW_JMP_PC(MEMW_JMP_PC)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    // scoreboard: every accepted store must match the oldest expected {addr, data}
    always @(negedge CLK) begin
        if (!RST && dbus.DATA_WREN && dbus.DATA_WREADY) begin
            logic [63:0] exp_v;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: got addr=%h data=%h, expected no store", dbus.DATA_WADDR, dbus.DATA_WDATA);
            end else begin
                exp_v = exp_q.pop_front();
                if ({dbus.DATA_WADDR, dbus.DATA_WDATA} !== exp_v) begin
                    errors++;
                    $display("FAIL store_data: got %h_%h, expected %h", dbus.DATA_WADDR, dbus.DATA_WDATA, exp_v);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        MEMR_REG_W_RD = '0; MEMR_REG_W_DATA = '0; MEMR_CSR_W_ADDR = '0; MEMR_CSR_W_DATA = '0;
        MEMR_MEM_W_VALID = 1'b0; MEMR_MEM_W_ADDR = '0; MEMR_MEM_W_STRB = '0; MEMR_MEM_W_DATA = '0;
        MEMR_JMP_DO = 1'b0; MEMR_JMP_PC = '0;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input bit expect_ok);
        MEMR_MEM_W_VALID = 1'b1; MEMR_MEM_W_ADDR = addr; MEMR_MEM_W_DATA = data; MEMR_MEM_W_STRB = 4'hF;
        if (expect_ok) exp_q.push_back({addr[31:2], 2'b00, data});
    endtask

    task automatic test_reset();
        MEMR_REG_W_RD = 5'd9; MEMR_REG_W_DATA = 32'hFFFF_0000; MEMR_CSR_W_ADDR = 12'h300;
        MEMR_CSR_W_DATA = 32'h1; MEMR_JMP_DO = 1'b1; MEMR_JMP_PC = 32'h100;
        drive_store(32'h0000_0040, 32'hAAAA_5555, 1'b0);
        RST = 1'b1;
        tick();
        tick();
        drive_idle();
        checks++; if (dbus.DATA_WREN !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b, expected 0", dbus.DATA_WREN); end
        checks++; if (MEMW_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", MEMW_BUSY); end
        checks++; if (MEMW_WERR !== 1'b0) begin errors++; $display("FAIL reset_werr: got %b, expected 0", MEMW_WERR); end
        checks++; if ({MEMW_REG_W_RD, MEMW_REG_W_DATA, MEMW_CSR_W_ADDR, MEMW_CSR_W_DATA} !== 81'h0) begin
            errors++; $display("FAIL reset_reg_csr: got rd=%h data=%h csr=%h/%h, expected 0", MEMW_REG_W_RD, MEMW_REG_W_DATA, MEMW_CSR_W_ADDR, MEMW_CSR_W_DATA); end
        checks++; if ({MEMW_JMP_DO, MEMW_JMP_PC, dbus.DATA_WADDR, dbus.DATA_WDATA} !== 97'h0) begin
            errors++; $display("FAIL reset_jmp_bus: got jmp=%b pc=%h addr=%h data=%h, expected 0", MEMW_JMP_DO, MEMW_JMP_PC, dbus.DATA_WADDR, dbus.DATA_WDATA); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_reg_pass();
        MEMR_REG_W_RD = 5'd5; MEMR_REG_W_DATA = 32'hDEAD_BEEF; MEMR_CSR_W_ADDR = 12'h305;
        MEMR_CSR_W_DATA = 32'h0000_1234; MEMR_JMP_DO = 1'b1; MEMR_JMP_PC = 32'h0000_0080;
        tick();
        drive_idle();
        checks++; if (MEMW_REG_W_RD !== 5'd5 || MEMW_REG_W_DATA !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL reg_pass: got rd=%0d data=%h, expected rd=5 data=deadbeef", MEMW_REG_W_RD, MEMW_REG_W_DATA); end
        checks++; if (MEMW_CSR_W_ADDR !== 12'h305 || MEMW_CSR_W_DATA !== 32'h1234) begin
            errors++; $display("FAIL csr_pass: got %h/%h, expected 305/00001234", MEMW_CSR_W_ADDR, MEMW_CSR_W_DATA); end
        checks++; if (MEMW_JMP_DO !== 1'b1 || MEMW_JMP_PC !== 32'h80) begin
            errors++; $display("FAIL jmp_pass: got %b/%h, expected 1/00000080", MEMW_JMP_DO, MEMW_JMP_PC); end
        checks++; if (MEMW_BUSY !== 1'b0 || dbus.DATA_WREN !== 1'b0) begin
            errors++; $display("FAIL reg_pass_busy: got busy=%b wren=%b, expected 0/0", MEMW_BUSY, dbus.DATA_WREN); end
        tick();
    endtask

    task automatic test_store_imm();
        dbus.DATA_WREADY = 1'b1;
        drive_store(32'h0000_1003, 32'h1122_3344, 1'b1);
        tick();
        drive_idle();
        checks++; if (dbus.DATA_WREN !== 1'b1 || MEMW_BUSY !== 1'b1) begin
            errors++; $display("FAIL imm_wren: got wren=%b busy=%b, expected 1/1", dbus.DATA_WREN, MEMW_BUSY); end
        checks++; if (dbus.DATA_WADDR !== 32'h1000 || dbus.DATA_WDATA !== 32'h1122_3344) begin
            errors++; $display("FAIL imm_bus: got %h/%h, expected 00001000/11223344", dbus.DATA_WADDR, dbus.DATA_WDATA); end
        tick();
        checks++; if (dbus.DATA_WREN !== 1'b0 || MEMW_BUSY !== 1'b0) begin
            errors++; $display("FAIL imm_done: got wren=%b busy=%b, expected 0/0", dbus.DATA_WREN, MEMW_BUSY); end
        dbus.DATA_WREADY = 1'b0;
        tick();
    endtask

    task automatic test_delay_flush();
        dbus.DATA_WREADY = 1'b0;
        MEMR_REG_W_RD = 5'd7; MEMR_REG_W_DATA = 32'h55; MEMR_JMP_DO = 1'b1; MEMR_JMP_PC = 32'h400;
        drive_store(32'h0000_2000, 32'hCAFE_F00D, 1'b1);
        tick();
        // new entry waiting upstream while busy must not be captured
        drive_idle();
        MEMR_REG_W_RD = 5'd9; MEMR_REG_W_DATA = 32'h99;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (dbus.DATA_WREN !== 1'b1 || dbus.DATA_WADDR !== 32'h2000 || dbus.DATA_WDATA !== 32'hCAFE_F00D) begin
                errors++; $display("FAIL delay_hold c%0d: got wren=%b %h/%h, expected 1 00002000/cafef00d", c, dbus.DATA_WREN, dbus.DATA_WADDR, dbus.DATA_WDATA); end
            if (c == 2) begin
                checks++; if (MEMW_REG_W_RD !== 5'd7 || MEMW_JMP_DO !== 1'b1) begin
                    errors++; $display("FAIL busy_no_capture: got rd=%0d jmp=%b, expected 7/1", MEMW_REG_W_RD, MEMW_JMP_DO); end
            end
            if (c == 3) begin
                checks++; if (MEMW_REG_W_RD !== 5'd0 || MEMW_REG_W_DATA !== 32'h0 || MEMW_JMP_DO !== 1'b0 || MEMW_JMP_PC !== 32'h0) begin
                    errors++; $display("FAIL flush_clear: got rd=%0d data=%h jmp=%b pc=%h, expected all 0", MEMW_REG_W_RD, MEMW_REG_W_DATA, MEMW_JMP_DO, MEMW_JMP_PC); end
            end
            FLUSH = (c == 2);
            dbus.DATA_WREADY = (c == 4);
            tick();
        end
        FLUSH = 1'b0;
        dbus.DATA_WREADY = 1'b0;
        checks++; if (dbus.DATA_WREN !== 1'b0 || MEMW_BUSY !== 1'b0 || MEMW_WERR !== 1'b0) begin
            errors++; $display("FAIL delay_done: got wren=%b busy=%b werr=%b, expected 0/0/0", dbus.DATA_WREN, MEMW_BUSY, MEMW_WERR); end
        checks++; if (MEMW_REG_W_RD !== 5'd0) begin
            errors++; $display("FAIL delay_no_capture: got rd=%0d, expected 0", MEMW_REG_W_RD); end
        drive_idle();
        tick();
    endtask

    task automatic test_timeout(input bit ready_last);
        dbus.DATA_WREADY = 1'b0;
        drive_store(32'h0000_3004 + (ready_last ? 32'h10 : 32'h0), $urandom, ready_last);
        tick();
        drive_idle();
        for (int c = 1; c <= 4; c++) begin
            checks++; if (dbus.DATA_WREN !== 1'b1 || MEMW_WERR !== 1'b0) begin
                errors++; $display("FAIL timeout_wait c%0d r%0d: got wren=%b werr=%b, expected 1/0", c, ready_last, dbus.DATA_WREN, MEMW_WERR); end
            dbus.DATA_WREADY = ready_last && (c == 4);
            tick();
        end
        dbus.DATA_WREADY = 1'b0;
        checks++; if (dbus.DATA_WREN !== 1'b0 || MEMW_BUSY !== 1'b0 || MEMW_WERR !== !ready_last) begin
            errors++; $display("FAIL timeout_end r%0d: got wren=%b busy=%b werr=%b, expected 0/0/%b", ready_last, dbus.DATA_WREN, MEMW_BUSY, MEMW_WERR, !ready_last); end
        tick();
        checks++; if (MEMW_WERR !== 1'b0) begin
            errors++; $display("FAIL werr_pulse r%0d: got %b, expected 0", ready_last, MEMW_WERR); end
    endtask

    task automatic test_mem_wait();
        MEMR_REG_W_RD = 5'd3; MEMR_REG_W_DATA = 32'hA5A5_0003;
        tick();
        MEM_WAIT = 1'b1;
        MEMR_REG_W_RD = 5'd12; MEMR_REG_W_DATA = $urandom;
        drive_store(32'h0000_4000, 32'h0BAD_0BAD, 1'b0);
        tick();
        tick();
        checks++; if (MEMW_REG_W_RD !== 5'd3 || MEMW_REG_W_DATA !== 32'hA5A5_0003) begin
            errors++; $display("FAIL mem_wait_hold: got rd=%0d data=%h, expected 3/a5a50003", MEMW_REG_W_RD, MEMW_REG_W_DATA); end
        checks++; if (MEMW_BUSY !== 1'b0 || dbus.DATA_WREN !== 1'b0) begin
            errors++; $display("FAIL mem_wait_nostore: got busy=%b wren=%b, expected 0/0", MEMW_BUSY, dbus.DATA_WREN); end
        MEM_WAIT = 1'b0;
        drive_idle();
        drive_store(32'h0000_4008, 32'h7777_8888, 1'b1);
        tick();
        drive_idle();
        // MEM_WAIT raised during the store must not block acceptance
        MEM_WAIT = 1'b1;
        dbus.DATA_WREADY = 1'b1;
        tick();
        checks++; if (dbus.DATA_WREN !== 1'b0 || MEMW_BUSY !== 1'b0) begin
            errors++; $display("FAIL mem_wait_accept: got wren=%b busy=%b, expected 0/0", dbus.DATA_WREN, MEMW_BUSY); end
        MEM_WAIT = 1'b0;
        dbus.DATA_WREADY = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid_write();
        drive_store(32'h0000_5000, 32'h5555_AAAA, 1'b0);
        tick();
        drive_idle();
        tick();
        checks++; if (dbus.DATA_WREN !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got wren=%b, expected 1", dbus.DATA_WREN); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++; if (dbus.DATA_WREN !== 1'b0 || MEMW_BUSY !== 1'b0 || MEMW_WERR !== 1'b0 || dbus.DATA_WADDR !== 32'h0) begin
            errors++; $display("FAIL rst_mid: got wren=%b busy=%b werr=%b addr=%h, expected 0/0/0/0", dbus.DATA_WREN, MEMW_BUSY, MEMW_WERR, dbus.DATA_WADDR); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (MEMW_WERR !== 1'b0 || dbus.DATA_WREN !== 1'b0) begin
                errors++; $display("FAIL rst_mid_after c%0d: got werr=%b wren=%b, expected 0/0", c, MEMW_WERR, dbus.DATA_WREN); end
        end
    endtask

    task automatic test_back_to_back();
        dbus.DATA_WREADY = 1'b1;
        drive_store(32'h0000_6000, 32'h0000_00A1, 1'b1);
        tick();
        drive_store(32'h0000_6005, 32'h0000_00B2, 1'b1);
        tick();
        checks++; if (dbus.DATA_WREN !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: got wren=%b, expected 0", dbus.DATA_WREN); end
        tick();
        drive_idle();
        checks++; if (dbus.DATA_WREN !== 1'b1 || dbus.DATA_WADDR !== 32'h6004) begin
            errors++; $display("FAIL b2b_second: got wren=%b addr=%h, expected 1/00006004", dbus.DATA_WREN, dbus.DATA_WADDR); end
        tick();
        checks++; if (dbus.DATA_WREN !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got wren=%b, expected 0", dbus.DATA_WREN); end
        dbus.DATA_WREADY = 1'b0;
        tick();
    endtask

    initial begin
        dbus.DATA_WREADY = 1'b0;
        test_reset();
        test_reg_pass();
        test_store_imm();
        test_delay_flush();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_mem_wait();
        test_rst_mid_write();
        test_back_to_back();
        tick();
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL store_pending: got %0d stores outstanding, expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
